// File: rtl/arm_pipe_pkg.sv
// Shared ARM pipeline definitions: word width, the NOP encoding (MOV r0,r0)
// and the update-selection helper for the fetch/decode pipeline register.
package arm_pipe_pkg;

   localparam int WORD_W = 32;
   localparam logic [WORD_W-1:0] NOP_WORD = 32'hE1A00000;

   typedef enum logic [1:0] {
      UPD_RESET = 2'd0,
      UPD_FLUSH = 2'd1,
      UPD_HOLD  = 2'd2,
      UPD_LOAD  = 2'd3
   } upd_e;

   // Update priority: reset, then flush (beats freeze), then hold, then load.
   function automatic upd_e sel_update(input logic rst, input logic flush, input logic freeze);
      upd_e sel;
      if (rst) begin
         sel = UPD_RESET;
      end else if (flush) begin
         sel = UPD_FLUSH;
      end else if (freeze) begin
         sel = UPD_HOLD;
      end else begin
         sel = UPD_LOAD;
      end
      return sel;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear beats increment.
module sat_counter #(
   parameter int CNT_W = 16
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_r;

   // Count state: reset/clear to zero, otherwise step up and stick at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r <= {CNT_W{1'b0}};
      end else if (clr) begin
         count_r <= {CNT_W{1'b0}};
      end else if (inc && (count_r != {CNT_W{1'b1}})) begin
         count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;

endmodule

// File: rtl/if_stage_reg.sv
// IF/ID pipeline register with flush/freeze and optional stall/flush counters.
// Counters are present only when IF_STAGE_REG_PERF_CNT_EN is defined.
module if_stage_reg
   import arm_pipe_pkg::*;
#(
   parameter logic [WORD_W-1:0] NOP_INSTR = NOP_WORD,
   parameter int                CNT_W     = 16
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic              flush,
   input  logic [WORD_W-1:0] pc_in,
   input  logic [WORD_W-1:0] instruction_in,
   input  logic              cnt_clr,
   output logic [WORD_W-1:0] pc_out,
   output logic [WORD_W-1:0] instruction_out,
   output logic              valid_out,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   logic [WORD_W-1:0] pc_r;
   logic [WORD_W-1:0] instr_r;
   logic              valid_r;
   upd_e              upd_s;

   assign upd_s = sel_update(rst, flush, freeze);

   // Pipeline register: a bubble on reset or flush, hold on freeze, else capture.
   always_ff @(posedge clk) begin
      case (upd_s)
         UPD_RESET, UPD_FLUSH: begin
            pc_r    <= {WORD_W{1'b0}};
            instr_r <= NOP_INSTR;
            valid_r <= 1'b0;
         end
         UPD_HOLD: begin
            pc_r    <= pc_r;
            instr_r <= instr_r;
            valid_r <= valid_r;
         end
         UPD_LOAD: begin
            pc_r    <= pc_in;
            instr_r <= instruction_in;
            valid_r <= 1'b1;
         end
         default: begin
            pc_r    <= {WORD_W{1'b0}};
            instr_r <= NOP_INSTR;
            valid_r <= 1'b0;
         end
      endcase
   end

   assign pc_out          = pc_r;
   assign instruction_out = instr_r;
   assign valid_out       = valid_r;

`ifdef IF_STAGE_REG_PERF_CNT_EN
   logic stall_inc_s;

   // A flush cycle counts as a flush, never as a stall.
   assign stall_inc_s = freeze & ~flush;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .inc   (stall_inc_s),
      .count (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .inc   (flush),
      .count (flush_cnt)
   );
`else
   logic unused_cnt_clr_s;

   assign unused_cnt_clr_s = cnt_clr;
   assign stall_cnt        = {CNT_W{1'b0}};
   assign flush_cnt        = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_if_stage_reg.sv
// Directed bench for if_stage_reg; counter expectations follow IF_STAGE_REG_PERF_CNT_EN.
module tb_if_stage_reg;

`ifdef IF_STAGE_REG_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif
   localparam logic [31:0] NOP = 32'hE1A00000;

   logic        clk = 1'b0;
   logic        rst, freeze, flush, cnt_clr;
   logic [31:0] pc_in, instruction_in;
   logic [31:0] pc_out, instruction_out, pc_out4, instruction_out4;
   logic        valid_out, valid_out4;
   logic [15:0] stall_cnt, flush_cnt;
   logic [3:0]  stall_cnt4, flush_cnt4;
   logic [15:0] exp16;
   logic [3:0]  exp4;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   if_stage_reg dut (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
      .pc_in(pc_in), .instruction_in(instruction_in), .cnt_clr(cnt_clr),
      .pc_out(pc_out), .instruction_out(instruction_out), .valid_out(valid_out),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   if_stage_reg #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
      .pc_in(pc_in), .instruction_in(instruction_in), .cnt_clr(cnt_clr),
      .pc_out(pc_out4), .instruction_out(instruction_out4), .valid_out(valid_out4),
      .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; freeze = 1'b1; flush = 1'b1; cnt_clr = 1'b1;
      pc_in = 32'h0000_1234; instruction_in = 32'hDEAD_BEEF;
      tick();
      checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", pc_out, 32'h0); end
      checks++; if (instruction_out !== NOP) begin errors++; $display("FAIL reset_instr got %h want %h", instruction_out, NOP); end
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_out); end
      checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall got %0d want 0", stall_cnt); end
      checks++; if (flush_cnt !== 16'd0) begin errors++; $display("FAIL reset_flush got %0d want 0", flush_cnt); end
   endtask

   task automatic test_load();
      rst = 1'b0; freeze = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
      pc_in = 32'h4; instruction_in = 32'hE3A01005;
      tick();
      checks++; if (pc_out !== 32'h4) begin errors++; $display("FAIL load1_pc got %h want %h", pc_out, 32'h4); end
      checks++; if (instruction_out !== 32'hE3A01005) begin errors++; $display("FAIL load1_instr got %h want %h", instruction_out, 32'hE3A01005); end
      checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL load1_valid got %b want 1", valid_out); end
      pc_in = 32'h8; instruction_in = 32'hE2811001;
      tick();
      checks++; if (pc_out !== 32'h8 || instruction_out !== 32'hE2811001 || valid_out !== 1'b1) begin
         errors++; $display("FAIL load2 got %h %h %b want 00000008 e2811001 1", pc_out, instruction_out, valid_out); end
   endtask

   task automatic test_freeze();
      freeze = 1'b1;
      for (int i = 0; i < 3; i++) begin
         pc_in = 32'h100 + 32'(i); instruction_in = 32'hE0000000 + 32'(i);
         tick();
         checks++; if (pc_out !== 32'h8 || instruction_out !== 32'hE2811001 || valid_out !== 1'b1) begin
            errors++; $display("FAIL freeze_hold%0d got %h %h %b want 00000008 e2811001 1", i, pc_out, instruction_out, valid_out); end
      end
      exp16 = PERF ? 16'd3 : 16'd0;
      checks++; if (stall_cnt !== exp16) begin errors++; $display("FAIL freeze_stall_cnt got %0d want %0d", stall_cnt, exp16); end
      freeze = 1'b0; pc_in = 32'hC; instruction_in = 32'hE1A02001;
      tick();
      checks++; if (pc_out !== 32'hC || instruction_out !== 32'hE1A02001 || valid_out !== 1'b1) begin
         errors++; $display("FAIL unfreeze_load got %h %h %b want 0000000c e1a02001 1", pc_out, instruction_out, valid_out); end
   endtask

   task automatic test_flush_freeze();
      flush = 1'b1; freeze = 1'b1; pc_in = 32'h10; instruction_in = 32'hE3A03007;
      tick();
      checks++; if (pc_out !== 32'h0 || instruction_out !== 32'hE1A00000 || valid_out !== 1'b0) begin
         errors++; $display("FAIL flush_bubble got %h %h %b want 00000000 e1a00000 0", pc_out, instruction_out, valid_out); end
      exp16 = PERF ? 16'd1 : 16'd0;
      checks++; if (flush_cnt !== exp16) begin errors++; $display("FAIL flush_cnt got %0d want %0d", flush_cnt, exp16); end
      exp16 = PERF ? 16'd3 : 16'd0;
      checks++; if (stall_cnt !== exp16) begin errors++; $display("FAIL flush_stall_cnt got %0d want %0d", stall_cnt, exp16); end
      flush = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++; if (valid_out !== 1'b0 || instruction_out !== NOP || pc_out !== 32'h0) begin
            errors++; $display("FAIL bubble_hold%0d got %h %h %b want 00000000 e1a00000 0", i, pc_out, instruction_out, valid_out); end
      end
      exp16 = PERF ? 16'd5 : 16'd0;
      checks++; if (stall_cnt !== exp16) begin errors++; $display("FAIL bubble_stall_cnt got %0d want %0d", stall_cnt, exp16); end
      freeze = 1'b0;
      tick();
      checks++; if (pc_out !== 32'h10 || instruction_out !== 32'hE3A03007 || valid_out !== 1'b1) begin
         errors++; $display("FAIL after_bubble_load got %h %h %b want 00000010 e3a03007 1", pc_out, instruction_out, valid_out); end
   endtask

   task automatic test_cnt_clr();
      freeze = 1'b1; cnt_clr = 1'b1;
      tick();
      checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
         errors++; $display("FAIL cnt_clr got %0d %0d want 0 0", stall_cnt, flush_cnt); end
      checks++; if (pc_out !== 32'h10 || valid_out !== 1'b1) begin
         errors++; $display("FAIL cnt_clr_hold got %h %b want 00000010 1", pc_out, valid_out); end
      cnt_clr = 1'b0; freeze = 1'b0;
   endtask

   task automatic test_saturation();
      rst = 1'b1;
      tick();
      rst = 1'b0; freeze = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      exp4 = PERF ? 4'd15 : 4'd0;
      checks++; if (stall_cnt4 !== exp4) begin errors++; $display("FAIL sat_cnt4 got %0d want %0d", stall_cnt4, exp4); end
      exp16 = PERF ? 16'd20 : 16'd0;
      checks++; if (stall_cnt !== exp16) begin errors++; $display("FAIL sat_cnt16 got %0d want %0d", stall_cnt, exp16); end
      cnt_clr = 1'b1;
      tick();
      checks++; if (stall_cnt4 !== 4'd0) begin errors++; $display("FAIL sat_clr got %0d want 0", stall_cnt4); end
      cnt_clr = 1'b0; freeze = 1'b0;
   endtask

   task automatic test_reset_mid_stall();
      pc_in = 32'h20; instruction_in = 32'hE5912000;
      tick();
      freeze = 1'b1; pc_in = 32'h24; instruction_in = 32'hE0811002;
      tick();
      tick();
      rst = 1'b1; flush = 1'b1; cnt_clr = 1'b1;
      tick();
      checks++; if (pc_out !== 32'h0 || instruction_out !== NOP || valid_out !== 1'b0 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
         errors++; $display("FAIL rst_mid_stall got %h %h %b %0d %0d want 00000000 e1a00000 0 0 0",
                            pc_out, instruction_out, valid_out, stall_cnt, flush_cnt); end
      rst = 1'b0; flush = 1'b0; freeze = 1'b0; cnt_clr = 1'b0;
      pc_in = 32'h40; instruction_in = 32'hE3A0000A;
      tick();
      checks++; if (pc_out !== 32'h40 || instruction_out !== 32'hE3A0000A || valid_out !== 1'b1) begin
         errors++; $display("FAIL post_rst_load got %h %h %b want 00000040 e3a0000a 1", pc_out, instruction_out, valid_out); end
   endtask

   initial begin
      test_reset();
      test_load();
      test_freeze();
      test_flush_freeze();
      test_cnt_clr();
      test_saturation();
      test_reset_mid_stall();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
